demux_bank: RTL and testbench

Write-side counterpart to the cell-select multiplexer: accepts one 9-bit word per handshake and stores it in one of nine slot registers chosen by a 4-bit select. Slot contents drive `out1`..`out9`, which feed the read mux. The block rejects out-of-range selects and writes to already-occupied slots. A clear request runs a 9-cycle sequential sweep that empties every slot before new writes are accepted.

---
 rtl/demux_bank.sv | 132 +++++++++++++
 tb/tb_demux_bank.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_bank.sv
// demux_bank: write-side slot bank feeding the cell-select read mux.
// Each accepted write stores one WIDTH-bit word into one of nine slots chosen by wr_sel.
// A write is rejected when the select is out of range or the slot is already written.
// A clear request starts a nine-cycle sweep. The sweep empties slots 0..8 in order, one per
// cycle, and writes are blocked until it finishes.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   wr_valid/wr_ready  write handshake; wr_sel selects slot 0..8; wr_data is the word
//   clr_req            start the clear sweep (takes priority over a same-cycle write)
//   busy               clear sweep in progress
//   err, err_code      one-cycle reject pulse; code 01 = bad select, 10 = slot occupied
//   written, full      per-slot occupancy bits; full when all nine are set
//   out1..out9         slot 0..8 contents
module demux_bank #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [8:0]       written,
  output logic             full,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] slot_q [9];
  logic [WIDTH-1:0] slot_d [9];
  logic [8:0]       written_q, written_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    written_d  = written_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    unique case (state_q)
      StIdle: begin
        // clr_req wins over a simultaneous write; that write is dropped, not queued.
        if (clr_req) begin
          state_d = StClear;
          idx_d   = 4'd0;
        end else if (wr_valid) begin
          if (wr_sel > 4'd8) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (written_q[wr_sel]) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            slot_d[wr_sel]    = wr_data;
            written_d[wr_sel] = 1'b1;
          end
        end
      end
      StClear: begin
        slot_d[idx_q]    = '0;
        written_d[idx_q] = 1'b0;
        if (idx_q == 4'd8) begin
          state_d = StIdle;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      written_q  <= 9'd0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      for (int i = 0; i < 9; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      written_q  <= written_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      for (int i = 0; i < 9; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign wr_ready = (state_q == StIdle) && !clr_req;
  assign busy     = (state_q == StClear);
  assign err      = err_q;
  assign err_code = err_code_q;
  assign written  = written_q;
  assign full     = &written_q;
  assign out1     = slot_q[0];
  assign out2     = slot_q[1];
  assign out3     = slot_q[2];
  assign out4     = slot_q[3];
  assign out5     = slot_q[4];
  assign out6     = slot_q[5];
  assign out7     = slot_q[6];
  assign out8     = slot_q[7];
  assign out9     = slot_q[8];

endmodule

// File: tb/tb_demux_bank.sv
module tb_demux_bank;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_sel;
  logic [8:0] wr_data;
  logic       clr_req;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  logic [8:0] written;
  logic       full;
  logic [8:0] out1, out2, out3, out4, out5, out6, out7, out8, out9;
  logic [8:0] dout [9];

  int checks;
  int errors;

  // Reference model: occupancy, contents and the number of sweep cycles still to run.
  logic [8:0] m_slot [9];
  logic [8:0] m_written;
  logic       m_err;
  logic [1:0] m_code;
  int         m_sweep_left;

  demux_bank #(.WIDTH(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .err      (err),
    .err_code (err_code),
    .written  (written),
    .full     (full),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4),
    .out5     (out5),
    .out6     (out6),
    .out7     (out7),
    .out8     (out8),
    .out9     (out9)
  );

  assign dout[0] = out1;
  assign dout[1] = out2;
  assign dout[2] = out3;
  assign dout[3] = out4;
  assign dout[4] = out5;
  assign dout[5] = out6;
  assign dout[6] = out7;
  assign dout[7] = out8;
  assign dout[8] = out9;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_slot[i] = 9'd0;
    m_written    = 9'd0;
    m_err        = 1'b0;
    m_code       = 2'b00;
    m_sweep_left = 0;
  endtask

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    int k;
    m_err = 1'b0;
    if (m_sweep_left > 0) begin
      k = 9 - m_sweep_left;
      m_slot[k]    = 9'd0;
      m_written[k] = 1'b0;
      m_sweep_left = m_sweep_left - 1;
    end else if (clr_req) begin
      m_sweep_left = 9;
    end else if (wr_valid) begin
      if (int'(wr_sel) > 8) begin
        m_err  = 1'b1;
        m_code = 2'b01;
      end else if (m_written[wr_sel]) begin
        m_err  = 1'b1;
        m_code = 2'b10;
      end else begin
        m_slot[wr_sel]    = wr_data;
        m_written[wr_sel] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dout[i] !== 9'd0) begin
        errors++;
        $display("FAIL reset_slot%0d: got %h expected 000", i, dout[i]);
      end
    end
    checks++;
    if ({written, full, err, err_code, busy, wr_ready} !== {9'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1})
    begin
      errors++;
      $display("FAIL reset_flags: got wr=%b full=%b err=%b code=%b busy=%b rdy=%b",
               written, full, err, err_code, busy, wr_ready);
    end
  endtask

  task automatic test_write_basic();
    wr_valid = 1'b1;
    wr_sel   = 4'd4;
    wr_data  = 9'h1A5;
    tick();
    wr_valid = 1'b0;
    checks++;
    if (out5 !== 9'h1A5) begin
      errors++;
      $display("FAIL write_out5: got %h expected 1a5", out5);
    end
    checks++;
    if (written !== 9'b000010000) begin
      errors++;
      $display("FAIL write_written: got %b expected 000010000", written);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL write_err: got %b expected 0", err);
    end
  endtask

  task automatic test_occupied();
    wr_valid = 1'b1;
    wr_sel   = 4'd4;
    wr_data  = 9'h0FF;
    tick();
    wr_valid = 1'b0;
    checks++;
    if (out5 !== 9'h1A5) begin
      errors++;
      $display("FAIL occ_out5: got %h expected 1a5", out5);
    end
    checks++;
    if ({err, err_code} !== 3'b110) begin
      errors++;
      $display("FAIL occ_err: got err=%b code=%b expected err=1 code=10", err, err_code);
    end
    tick();
    checks++;
    if ({err, err_code} !== 3'b010) begin
      errors++;
      $display("FAIL occ_pulse: got err=%b code=%b expected err=0 code=10", err, err_code);
    end
  endtask

  task automatic test_range();
    wr_valid = 1'b1;
    wr_sel   = 4'd11;
    wr_data  = 9'h123;
    tick();
    wr_valid = 1'b0;
    checks++;
    if ({err, err_code} !== 3'b101) begin
      errors++;
      $display("FAIL range_err: got err=%b code=%b expected err=1 code=01", err, err_code);
    end
    checks++;
    if (written !== 9'b000010000) begin
      errors++;
      $display("FAIL range_written: got %b expected 000010000", written);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dout[i] !== ((i == 4) ? 9'h1A5 : 9'd0)) begin
        errors++;
        $display("FAIL range_slot%0d: got %h", i, dout[i]);
      end
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL range_pulse: got %b expected 0", err);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    wr_valid = 1'b1;
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (full !== 1'b0) begin
        errors++;
        $display("FAIL b2b_full_early%0d: got %b expected 0", n, full);
      end
      wr_sel  = 4'(n);
      wr_data = 9'(n + 1);
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if ({full, written} !== {1'b1, 9'h1FF}) begin
      errors++;
      $display("FAIL b2b_full: got full=%b written=%b expected 1/111111111", full, written);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dout[i] !== 9'(i + 1)) begin
        errors++;
        $display("FAIL b2b_out%0d: got %h expected %h", i + 1, dout[i], 9'(i + 1));
      end
    end
  endtask

  task automatic test_clear();
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_sel   = 4'd0;
    wr_data  = 9'h055;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready_same: got %b expected 0", wr_ready);
    end
    tick();  // edge T
    clr_req = 1'b0;
    // Keep wr_valid high: it must be ignored during the sweep.
    checks++;
    if ({busy, wr_ready, err} !== 3'b100 || out1 !== 9'd1) begin
      errors++;
      $display("FAIL clr_start: got busy=%b rdy=%b err=%b out1=%h", busy, wr_ready, err, out1);
    end
    for (int k = 0; k < 9; k++) begin
      tick();  // edge T+1+k
      for (int j = 0; j < 9; j++) begin
        checks++;
        if (dout[j] !== ((j <= k) ? 9'd0 : 9'(j + 1))) begin
          errors++;
          $display("FAIL clr_step%0d_slot%0d: got %h", k, j, dout[j]);
        end
      end
      checks++;
      if ({busy, wr_ready, err} !== {(k < 8), (k == 8), 1'b0}) begin
        errors++;
        $display("FAIL clr_step%0d_flags: got busy=%b rdy=%b err=%b", k, busy, wr_ready, err);
      end
    end
    checks++;
    if ({full, written} !== 10'd0) begin
      errors++;
      $display("FAIL clr_empty: got full=%b written=%b expected 0", full, written);
    end
    tick();  // edge T+10 accepts the still-pending write
    wr_valid = 1'b0;
    checks++;
    if (out1 !== 9'h055 || written !== 9'b000000001 || err !== 1'b0) begin
      errors++;
      $display("FAIL clr_after_write: got out1=%h written=%b err=%b", out1, written, err);
    end
  endtask

  task automatic test_reset_mid_sweep();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dout[i] !== 9'd0) begin
        errors++;
        $display("FAIL midrst_slot%0d: got %h expected 000", i, dout[i]);
      end
    end
    checks++;
    if ({written, busy, err, err_code} !== 13'd0) begin
      errors++;
      $display("FAIL midrst_flags: got written=%b busy=%b err=%b code=%b",
               written, busy, err, err_code);
    end
    #2;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    wr_valid = 1'b1;
    wr_sel   = 4'd2;
    wr_data  = 9'h007;
    tick();
    wr_valid = 1'b0;
    checks++;
    if (out3 !== 9'h007 || written !== 9'b000000100 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_write: got out3=%h written=%b busy=%b", out3, written, busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_sel   = 4'($urandom_range(0, 15));
      wr_data  = 9'($urandom);
      clr_req  = ($urandom_range(0, 19) == 0);
      #1;
      checks++;
      if (wr_ready !== ((m_sweep_left == 0) && !clr_req)) begin
        errors++;
        $display("FAIL rnd%0d_ready: got %b", c, wr_ready);
      end
      tick();
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (dout[i] !== m_slot[i]) begin
          errors++;
          $display("FAIL rnd%0d_slot%0d: got %h expected %h", c, i, dout[i], m_slot[i]);
        end
      end
      checks++;
      if ({written, full, err, err_code, busy} !==
          {m_written, &m_written, m_err, m_code, (m_sweep_left > 0)}) begin
        errors++;
        $display("FAIL rnd%0d_flags: got wr=%b full=%b err=%b code=%b busy=%b exp wr=%b err=%b code=%b",
                 c, written, full, err, err_code, busy, m_written, m_err, m_code);
      end
    end
    wr_valid = 1'b0;
    clr_req  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_sel   = 4'd0;
    wr_data  = 9'd0;
    clr_req  = 1'b0;
    model_reset();
    test_reset();
    test_write_basic();
    test_occupied();
    test_range();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    apply_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
